mdu_iter: RTL and testbench

//  Iterative multiply/divide unit for the RV32M extension, alongside the single-cycle ALU in EX.

---
 rtl/mdu_pkg.sv | 44 ++++
 rtl/mdu_div_step.sv | 26 ++
 rtl/mdu_iter.sv | 169 ++++++++++++++++
 tb/tb_mdu_iter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit: funct3 op codes,
// FSM state encoding and op-decode helpers.
package mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_MULHU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU) || (op == MDU_REM) || (op == MDU_REMU);
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return (op == MDU_REM) || (op == MDU_REMU);
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic is_high(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_MULHU);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// subtract the divisor when it fits and record the quotient bit.
module mdu_div_step
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // diff[XLEN] is the borrow: set when the divisor does not fit
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {1'b0, div_i};
        quo_o   = {quo_i[XLEN-2:0], ~diff[XLEN]};
        rem_o   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one bit per cycle (shift-add multiply, restoring divide).
// Optional single-cycle multiply when MDU_FAST_MUL_EN is defined.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      mdu_op_i,
    input  logic [XLEN-1:0] mdu_a_i,
    input  logic [XLEN-1:0] mdu_b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] mdu_result_o
);

    localparam int unsigned DW = 2 * XLEN;
    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e      state_q;
    logic [2:0]      op_q;
    logic            neg_q;
    logic [XLEN-1:0] opnd_q;
    logic [DW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;

    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            in_neg;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    logic [XLEN:0]   mul_sum;
    logic [DW-1:0]   mul_next;
    logic [XLEN-1:0] div_rem;
    logic [XLEN-1:0] div_quo;
    logic [DW-1:0]   step_next;
    logic [DW-1:0]   prod_fix;
    logic [XLEN-1:0] div_word;
    logic [XLEN-1:0] fix_res;

    assign in_ready_o = (state_q == ST_IDLE) && !flush_i;

    // Operand magnitudes, result sign and the divide corner cases resolved at accept
    always_comb begin
        a_neg    = is_signed_a(mdu_op_i) & mdu_a_i[XLEN-1];
        b_neg    = is_signed_b(mdu_op_i) & mdu_b_i[XLEN-1];
        abs_a    = a_neg ? -mdu_a_i : mdu_a_i;
        abs_b    = b_neg ? -mdu_b_i : mdu_b_i;
        in_neg   = is_rem(mdu_op_i) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div(mdu_op_i) && (mdu_b_i == '0);
        div_ovf  = is_signed_b(mdu_op_i) && is_div(mdu_op_i)
                   && (mdu_a_i == MIN_INT) && (mdu_b_i == '1);
        if (div_zero) begin
            special_res = is_rem(mdu_op_i) ? mdu_a_i : '1;
        end else begin
            special_res = is_rem(mdu_op_i) ? '0 : MIN_INT;
        end
    end

    mdu_div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_i (acc_q[DW-1:XLEN]),
        .quo_i (acc_q[XLEN-1:0]),
        .div_i (opnd_q),
        .rem_o (div_rem),
        .quo_o (div_quo)
    );

    // Multiply keeps the multiplier in the low half and shifts the product in from the top
    always_comb begin
        mul_sum   = {1'b0, acc_q[DW-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        step_next = is_div(op_q) ? {div_rem, div_quo} : mul_next;
        prod_fix  = neg_q ? -step_next : step_next;
        div_word  = is_rem(op_q) ? step_next[DW-1:XLEN] : step_next[XLEN-1:0];
        if (is_div(op_q)) begin
            fix_res = neg_q ? -div_word : div_word;
        end else begin
            fix_res = is_high(op_q) ? prod_fix[DW-1:XLEN] : prod_fix[XLEN-1:0];
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic [DW-1:0]   fast_a;
    logic [DW-1:0]   fast_b;
    logic [DW-1:0]   fast_prod;
    logic [XLEN-1:0] fast_res;

    // Sign/zero-extended operands so the low DW bits of the product are exact
    always_comb begin
        fast_a    = {{XLEN{is_signed_a(mdu_op_i) & mdu_a_i[XLEN-1]}}, mdu_a_i};
        fast_b    = {{XLEN{is_signed_b(mdu_op_i) & mdu_b_i[XLEN-1]}}, mdu_b_i};
        fast_prod = fast_a * fast_b;
        fast_res  = is_high(mdu_op_i) ? fast_prod[DW-1:XLEN] : fast_prod[XLEN-1:0];
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            out_valid_o  <= 1'b0;
            mdu_result_o <= '0;
            cnt_q        <= '0;
            op_q         <= '0;
            neg_q        <= 1'b0;
            opnd_q       <= '0;
            acc_q        <= '0;
        end else if (flush_i) begin
            state_q     <= ST_IDLE;
            out_valid_o <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        op_q   <= mdu_op_i;
                        neg_q  <= in_neg;
                        cnt_q  <= CW'(XLEN - 1);
                        opnd_q <= is_div(mdu_op_i) ? abs_b : abs_a;
                        acc_q  <= {{XLEN{1'b0}}, (is_div(mdu_op_i) ? abs_a : abs_b)};
                        if (div_zero || div_ovf) begin
                            mdu_result_o <= special_res;
                            out_valid_o  <= 1'b1;
                            state_q      <= ST_DONE;
`ifdef MDU_FAST_MUL_EN
                        end else if (is_mul(mdu_op_i)) begin
                            mdu_result_o <= fast_res;
                            out_valid_o  <= 1'b1;
                            state_q      <= ST_DONE;
`endif
                        end else begin
                            state_q <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    acc_q <= step_next;
                    if (cnt_q == '0) begin
                        mdu_result_o <= fix_res;
                        out_valid_o  <= 1'b1;
                        state_q      <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_o <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (XLEN=32): directed RV32M cases plus random traffic
// checked every cycle against a latency/arithmetic reference model.
`timescale 1ns/1ps
module tb_mdu_iter;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit          m_busy  = 1'b0;
    bit          m_valid = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_res   = 32'd0;
    logic [31:0] m_pend  = 32'd0;

    mdu_iter #(.XLEN(32)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .mdu_op_i     (op),
        .mdu_a_i      (a),
        .mdu_b_i      (b),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .mdu_result_o (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] fop, input logic [31:0] fa,
                                            input logic [31:0] fb);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        int          sa;
        int          sb;
        logic        ovf;
        sa  = fa;
        sb  = fb;
        ovf = (fa == 32'h8000_0000) && (fb == 32'hffff_ffff);
        ea  = (fop == 3'd1 || fop == 3'd2) ? {{32{fa[31]}}, fa} : {32'd0, fa};
        eb  = (fop == 3'd1) ? {{32{fb[31]}}, fb} : {32'd0, fb};
        p   = ea * eb;
        case (fop)
            3'd0:    return p[31:0];
            3'd1,
            3'd2,
            3'd3:    return p[63:32];
            3'd4:    return (fb == 0) ? 32'hffff_ffff : (ovf ? fa : 32'(sa / sb));
            3'd5:    return (fb == 0) ? 32'hffff_ffff : fa / fb;
            3'd6:    return (fb == 0) ? fa : (ovf ? 32'd0 : 32'(sa % sb));
            default: return (fb == 0) ? fa : fa % fb;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] fop, input logic [31:0] fa,
                                   input logic [31:0] fb);
        if (fop < 3'd4) return MUL_LAT;
        if (fb == 0) return 1;
        if ((fop == 3'd4 || fop == 3'd6) && fa == 32'h8000_0000 && fb == 32'hffff_ffff) return 1;
        return DIV_LAT;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hffff_ffff;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Transaction-level model: accept when idle, deliver after the op's latency
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_cnt   = 0;
        end else if (flush) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy  = 1'b0;
                m_valid = 1'b1;
                m_res   = m_pend;
            end
        end else if (in_valid) begin
            if (ref_lat(op, a, b) == 1) begin
                m_valid = 1'b1;
                m_res   = ref_res(op, a, b);
            end else begin
                m_busy = 1'b1;
                m_cnt  = ref_lat(op, a, b) - 1;
                m_pend = ref_res(op, a, b);
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("valid_in_reset", 32'(out_valid), 32'd0);
        end else begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("in_ready", 32'(in_ready), 32'(!m_busy && !m_valid && !flush));
            if (m_valid) chk("result", result, m_res);
        end
    end

    task automatic do_op(input string name, input logic [2:0] fop, input logic [31:0] fa,
                         input logic [31:0] fb, input logic [31:0] exp, input int lat,
                         input int hold);
        int  n;
        bit  found;
        @(posedge clk); #2;
        in_valid = 1'b1; op = fop; a = fa; b = fb;
        @(posedge clk); #2;
        in_valid = 1'b0;
        n = 0;
        found = 1'b0;
        while (n < 100 && !found) begin
            @(negedge clk);
            n++;
            if (out_valid) found = 1'b1;
        end
        chk({name, "_seen"}, 32'(found), 32'd1);
        chk({name, "_lat"}, 32'(n), 32'(lat));
        chk({name, "_res"}, result, exp);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk({name, "_hold_res"}, result, exp);
            chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({name, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
        @(negedge clk);
        chk({name, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_result", result, 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(in_ready), 32'd1);

        chk("model_mul",    ref_res(3'd0, 32'd7, 32'hffff_fffd), 32'hffff_ffeb);
        chk("model_mulhsu", ref_res(3'd2, 32'hffff_ffff, 32'hffff_ffff), 32'hffff_ffff);
        chk("model_rem",    ref_res(3'd6, 32'hffff_fff9, 32'd2), 32'hffff_ffff);

        do_op("mul",    3'd0, 32'd7,          32'hffff_fffd, 32'hffff_ffeb, MUL_LAT, 0);
        do_op("mulhu",  3'd3, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, MUL_LAT, 0);
        do_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 0);
        do_op("mulhsu", 3'd2, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, MUL_LAT, 0);
        do_op("div",    3'd4, 32'hffff_fff9, 32'd2,         32'hffff_fffd, DIV_LAT, 0);
        do_op("rem",    3'd6, 32'hffff_fff9, 32'd2,         32'hffff_ffff, DIV_LAT, 0);
        do_op("divu",   3'd5, 32'd100,       32'd7,         32'd14,        DIV_LAT, 0);
        do_op("remu",   3'd7, 32'd100,       32'd7,         32'd2,         DIV_LAT, 0);
        do_op("divu0",  3'd5, 32'd5,         32'd0,         32'hffff_ffff, 1, 0);
        do_op("remu0",  3'd7, 32'd5,         32'd0,         32'd5,         1, 0);
        do_op("divovf", 3'd4, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1, 0);
        do_op("removf", 3'd6, 32'h8000_0000, 32'hffff_ffff, 32'd0,         1, 0);
        do_op("bp",     3'd5, 32'd100,       32'd7,         32'd14,        DIV_LAT, 10);

        // flush in the fifth busy cycle
        @(posedge clk); #2;
        in_valid = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd7;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_no_valid", 32'(seen), 32'd0);
        do_op("post_flush", 3'd5, 32'd9, 32'd3, 32'd3, DIV_LAT, 0);

        // async reset mid-busy
        @(posedge clk); #2;
        in_valid = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_busy_valid", 32'(out_valid), 32'd0);
        chk("rst_busy_result", result, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // async reset while holding a result
        @(posedge clk); #2;
        in_valid = 1'b1; op = 3'd5; a = 32'd5; b = 32'd0;
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_done_pre", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_done_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_done_ready", 32'(in_ready), 32'd1);
        do_op("mul34", 3'd0, 32'd3, 32'd4, 32'd12, MUL_LAT, 0);

        // random traffic with backpressure and occasional flush
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            in_valid  = ($urandom_range(0, 99) < 50);
            op        = 3'($urandom_range(0, 7));
            a         = pick();
            b         = pick();
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #2;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #2 out_ready = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
